jk_excitation_sequencer: RTL and testbench

- Drives a bank of external JK flip-flops so that their outputs step through a programmed state sequence. It computes J/K from the excitation table, which is the inverse of the JK characteristic table.
- Reads the flops' Q back each cycle and flags any step where Q did not reach the target.
- Optional T-emulation mode drives J=K=T, so the same JK bank behaves as T flip-flops.
- Sits beside the JK flop bank as its controller and checker.

---
 rtl/jk_excitation_sequencer_if.sv | 32 +++
 rtl/jk_excitation_sequencer.sv | 106 ++++++++++
 tb/tb_jk_excitation_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_sequencer_if.sv
// Bus between the JK excitation sequencer and its environment: table load, run control,
// flop-bank drive and readback, and check status.
interface jk_excitation_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    seq_last;
    logic             tmode;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic [AW-1:0]    step_idx;
    logic             wrap;
    logic             mismatch;
    logic [AW-1:0]    mismatch_idx;

    modport master (
        output wr_en, wr_addr, wr_data, seq_last, tmode, start, stop, q_fb,
        input  j_out, k_out, busy, step_idx, wrap, mismatch, mismatch_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, seq_last, tmode, start, stop, q_fb,
        output j_out, k_out, busy, step_idx, wrap, mismatch, mismatch_idx
    );
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Steps an external JK flop bank through a programmed target table, deriving J/K from the
// excitation table (or J=K=T), and flags the first step whose Q readback missed its target.
module jk_excitation_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic                      clk,
    input logic                      reset,
    jk_excitation_sequencer_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [AW-1:0]    step_q;
    logic [AW-1:0]    last_q;
    logic             tmode_q;
    logic             wrap_q;
    logic             chk_valid_q;
    logic [WIDTH-1:0] exp_q;
    logic [AW-1:0]    exp_idx_q;
    logic             mm_q;
    logic [AW-1:0]    mm_idx_q;

    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;

    assign tgt = tbl_q[step_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            step_q      <= '0;
            last_q      <= '0;
            tmode_q     <= 1'b0;
            wrap_q      <= 1'b0;
            chk_valid_q <= 1'b0;
            exp_q       <= '0;
            exp_idx_q   <= '0;
            mm_q        <= 1'b0;
            mm_idx_q    <= '0;
        end else begin
            wrap_q <= 1'b0;
            // Readback of the step driven last cycle; only the first miss is recorded.
            if (chk_valid_q && (bus.q_fb != exp_q) && !mm_q) begin
                mm_q     <= 1'b1;
                mm_idx_q <= exp_idx_q;
            end
            case (state_q)
                StIdle: begin
                    chk_valid_q <= 1'b0;
                    if (bus.wr_en) tbl_q[bus.wr_addr] <= bus.wr_data;
                    if (bus.start) begin
                        state_q  <= StRun;
                        step_q   <= '0;
                        last_q   <= bus.seq_last;
                        tmode_q  <= bus.tmode;
                        mm_q     <= 1'b0;
                        mm_idx_q <= '0;
                    end
                end
                StRun: begin
                    // The step driven this cycle is checked even when stop aborts the run.
                    exp_q       <= tgt;
                    exp_idx_q   <= step_q;
                    chk_valid_q <= 1'b1;
                    if (bus.stop) begin
                        state_q <= StIdle;
                        step_q  <= '0;
                    end else if (step_q == last_q) begin
                        step_q <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        step_q <= step_q + AW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        j_d = '0;
        k_d = '0;
        if (state_q == StRun) begin
            if (tmode_q) begin
                j_d = bus.q_fb ^ tgt;
                k_d = bus.q_fb ^ tgt;
            end else begin
                j_d = ~bus.q_fb & tgt;
                k_d = bus.q_fb & ~tgt;
            end
        end
    end

    assign bus.j_out        = j_d;
    assign bus.k_out        = k_d;
    assign bus.busy         = (state_q == StRun);
    assign bus.step_idx     = step_q;
    assign bus.wrap         = wrap_q;
    assign bus.mismatch     = mm_q;
    assign bus.mismatch_idx = mm_idx_q;
endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Bench for jk_excitation_sequencer: excitation vectors with forced Q, then directed and
// randomized runs against an ideal (optionally stuck-bit) JK bank and a step-level model.
module tb_jk_excitation_sequencer;
    localparam int W = 4;
    localparam int D = 8;
    localparam int A = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jk_excitation_sequencer_if #(.WIDTH(W), .AW(A)) vif ();

    jk_excitation_sequencer #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    // Environment: ideal JK bank, output bits optionally stuck at 0, or Q forced directly.
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] stuck_mask = '0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_q = '0;

    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
        logic [W-1:0] n;
        for (int b = 0; b < W; b++) begin
            case ({j[b], k[b]})
                2'b00:   n[b] = q[b];
                2'b01:   n[b] = 1'b0;
                2'b10:   n[b] = 1'b1;
                default: n[b] = ~q[b];
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) bank_q <= jk_next(bank_q, vif.j_out, vif.k_out);
    assign vif.q_fb = force_en ? force_q : (bank_q & ~stuck_mask);

    // Reference: excitation table row by row, and J=K=T in T-emulation.
    function automatic logic [2*W-1:0] exc(input logic [W-1:0] q, input logic [W-1:0] t,
                                           input logic tm);
        logic [W-1:0] j;
        logic [W-1:0] k;
        for (int b = 0; b < W; b++) begin
            if (tm) begin
                j[b] = q[b] ^ t[b];
                k[b] = j[b];
            end else begin
                case ({q[b], t[b]})
                    2'b00: begin j[b] = 1'b0; k[b] = 1'b0; end
                    2'b01: begin j[b] = 1'b1; k[b] = 1'b0; end
                    2'b10: begin j[b] = 1'b0; k[b] = 1'b1; end
                    default: begin j[b] = 1'b0; k[b] = 1'b0; end
                endcase
            end
        end
        return {j, k};
    endfunction

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] model_tbl [D];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
        end
    endtask

    task automatic write_tbl(input int a, input logic [W-1:0] d);
        vif.wr_en   = 1'b1;
        vif.wr_addr = A'(a);
        vif.wr_data = d;
        @(negedge clk);
        vif.wr_en = 1'b0;
        model_tbl[a] = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(vif.busy), 0);
        chk({tag, " step_idx"}, 32'(vif.step_idx), 0);
        chk({tag, " j_out"}, 32'(vif.j_out), 0);
        chk({tag, " k_out"}, 32'(vif.k_out), 0);
        chk({tag, " wrap"}, 32'(vif.wrap), 0);
    endtask

    // Start a run, check every cycle against the model, stop on the last cycle, then check
    // the hold cycle and the late check that follows it.
    task automatic run_seq(input int last, input bit tm, input int ncyc,
                           input logic [W-1:0] stuck, input bit wr_noise);
        int           first_bad;
        int           bad_idx;
        logic [W-1:0] prev_tgt;
        int           prev_step;
        logic [W-1:0] q;
        stuck_mask   = stuck;
        vif.seq_last = A'(last);
        vif.tmode    = tm;
        vif.start    = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        first_bad = -1;
        bad_idx   = 0;
        prev_tgt  = '0;
        prev_step = 0;
        for (int c = 0; c < ncyc; c++) begin
            int           st;
            logic [W-1:0] tgt;
            logic [2*W-1:0] jk;
            st  = c % (last + 1);
            tgt = model_tbl[st];
            q   = vif.q_fb;
            if (c >= 1 && first_bad < 0 && q != prev_tgt) begin
                first_bad = c;
                bad_idx   = prev_step;
            end
            jk = exc(q, tgt, tm);
            chk("run busy", 32'(vif.busy), 1);
            chk("run step_idx", 32'(vif.step_idx), 32'(st));
            chk("run wrap", 32'(vif.wrap), 32'(c >= 1 && st == 0));
            chk("run j_out", 32'(vif.j_out), 32'(jk[2*W-1:W]));
            chk("run k_out", 32'(vif.k_out), 32'(jk[W-1:0]));
            chk("run mismatch", 32'(vif.mismatch), 32'(first_bad >= 0 && c > first_bad));
            if (first_bad >= 0 && c > first_bad)
                chk("run mismatch_idx", 32'(vif.mismatch_idx), 32'(bad_idx));
            prev_tgt  = tgt;
            prev_step = st;
            vif.wr_en   = wr_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            vif.wr_addr = A'($urandom_range(0, D - 1));
            vif.wr_data = W'($urandom);
            if (c == ncyc - 1) vif.stop = 1'b1;
            @(negedge clk);
        end
        vif.stop  = 1'b0;
        vif.wr_en = 1'b0;
        q = vif.q_fb;
        if (first_bad < 0 && q != prev_tgt) begin
            first_bad = ncyc;
            bad_idx   = prev_step;
        end
        chk_idle("stop");
        chk("stop mismatch", 32'(vif.mismatch), 32'(first_bad >= 0 && ncyc > first_bad));
        if (stuck == '0) chk("stop q holds", 32'(q), 32'(prev_tgt));
        @(negedge clk);
        chk("late mismatch", 32'(vif.mismatch), 32'(first_bad >= 0));
        if (first_bad >= 0) chk("late mismatch_idx", 32'(vif.mismatch_idx), 32'(bad_idx));
        chk("late q holds", 32'(vif.q_fb), 32'(q));
    endtask

    typedef struct {
        logic [W-1:0] tgt;
        logic [W-1:0] q;
        bit           tm;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{tgt: 4'h1, q: 4'h0, tm: 1'b0, j: 4'h1, k: 4'h0};
        vecs[1] = '{tgt: 4'h3, q: 4'h1, tm: 1'b1, j: 4'h2, k: 4'h2};
        vecs[2] = '{tgt: 4'h3, q: 4'h1, tm: 1'b0, j: 4'h2, k: 4'h0};
        vecs[3] = '{tgt: 4'h0, q: 4'hF, tm: 1'b0, j: 4'h0, k: 4'hF};
        vecs[4] = '{tgt: 4'hA, q: 4'h5, tm: 1'b0, j: 4'hA, k: 4'h5};
        vecs[5] = '{tgt: 4'hA, q: 4'h5, tm: 1'b1, j: 4'hF, k: 4'hF};
        vecs[6] = '{tgt: 4'h6, q: 4'h6, tm: 1'b0, j: 4'h0, k: 4'h0};
        vecs[7] = '{tgt: 4'hC, q: 4'h9, tm: 1'b0, j: 4'h4, k: 4'h1};
        vecs[8] = '{tgt: 4'hC, q: 4'h9, tm: 1'b1, j: 4'h5, k: 4'h5};

        reset = 1'b1;
        vif.wr_en = 1'b0; vif.wr_addr = '0; vif.wr_data = '0;
        vif.seq_last = '0; vif.tmode = 1'b0; vif.start = 1'b0; vif.stop = 1'b0;
        for (int i = 0; i < D; i++) model_tbl[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        chk("reset mismatch", 32'(vif.mismatch), 0);
        chk("reset mismatch_idx", 32'(vif.mismatch_idx), 0);

        // Stop in IDLE is ignored.
        vif.stop = 1'b1;
        @(negedge clk);
        vif.stop = 1'b0;
        chk_idle("idle stop");

        // Excitation vectors with Q forced, single-step sequence.
        force_en = 1'b1;
        for (int v = 0; v < 9; v++) begin
            write_tbl(0, vecs[v].tgt);
            force_q      = vecs[v].q;
            vif.seq_last = '0;
            vif.tmode    = vecs[v].tm;
            vif.start    = 1'b1;
            @(negedge clk);
            vif.start = 1'b0;
            chk("vec busy", 32'(vif.busy), 1);
            chk("vec j_out", 32'(vif.j_out), 32'(vecs[v].j));
            chk("vec k_out", 32'(vif.k_out), 32'(vecs[v].k));
            vif.stop = 1'b1;
            @(negedge clk);
            vif.stop = 1'b0;
            chk_idle("vec stop");
        end
        force_en = 1'b0;
        @(negedge clk);

        // Table 1,3,2,0 through the ideal bank; 12 cycles ends at step 3 so Q returns to 0.
        write_tbl(0, 4'h1); write_tbl(1, 4'h3); write_tbl(2, 4'h2); write_tbl(3, 4'h0);
        for (int i = 4; i < D; i++) write_tbl(i, 4'h0);
        run_seq(3, 1'b0, 12, '0, 1'b0);
        chk("bank at 0", 32'(vif.q_fb), 0);
        // Same table in T-emulation, stopped at step 2 with writes attempted during the run.
        run_seq(3, 1'b1, 11, '0, 1'b1);
        run_seq(3, 1'b0, 5, '0, 1'b0);

        // Bit 2 stuck at 0 against a target of 4'h4 at step 1, then a clean restart.
        write_tbl(1, 4'h4);
        run_seq(3, 1'b0, 9, 4'h4, 1'b1);
        run_seq(3, 1'b0, 8, '0, 1'b0);

        // Single-entry loop.
        write_tbl(0, 4'hA);
        run_seq(0, 1'b0, 6, '0, 1'b0);

        // Start in the same cycle as a write: the new value is driven at step 0.
        vif.wr_en = 1'b1; vif.wr_addr = '0; vif.wr_data = 4'h5;
        vif.seq_last = A'(1); vif.tmode = 1'b0; vif.start = 1'b1;
        model_tbl[0] = 4'h5;
        @(negedge clk);
        vif.wr_en = 1'b0; vif.start = 1'b0;
        chk("wr+start j_out", 32'(vif.j_out), 32'(~vif.q_fb & 4'h5));
        vif.stop = 1'b1;
        @(negedge clk);
        vif.stop = 1'b0;
        @(negedge clk);

        // Reset mid-run at step 2 wipes the table.
        vif.seq_last = A'(3); vif.tmode = 1'b0; vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        @(negedge clk);
        chk("pre-reset step_idx", 32'(vif.step_idx), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("midrun reset");
        chk("midrun reset mismatch", 32'(vif.mismatch), 0);
        for (int i = 0; i < D; i++) model_tbl[i] = '0;
        run_seq(3, 1'b0, 6, '0, 1'b0);
        chk("table cleared q", 32'(vif.q_fb), 0);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) write_tbl($urandom_range(0, D - 1), W'($urandom));
            run_seq($urandom_range(0, D - 1), 1'($urandom_range(0, 1)), $urandom_range(1, 20),
                    ($urandom_range(0, 3) == 0) ? W'($urandom) : '0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
